mod_counter: RTL

- Parametrised up/down counter: successor to the fixed 4-bit free-running counter.
- Generalised width, runtime modulo limit, direction, wrap/saturate mode, synchronous load, enable.
- Adds registered terminal-count pulse and sticky overflow flag.
- Used as the common timer/index primitive in datapaths and controllers.

---
 rtl/mod_counter.sv | 96 +++++++++
 1 files changed

// File: rtl/mod_counter.sv
// mod_counter: parametrised up/down modulo counter.
//
// Counts over 0..io_limit (inclusive) in either direction, with a wrap or
// saturate policy at the bounds, a synchronous load, and an enable. A
// boundary event occurs when the count would leave the range:
//   - counting up from io_limit, or from any value above it;
//   - counting down from 0.
// Each boundary event gives a registered one-cycle io_tc pulse and sets
// the sticky io_ovf flag.
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous, active-high reset
//   io_en        count enable
//   io_up        direction: 1 = up, 0 = down
//   io_sat       1 = saturate at the bounds, 0 = wrap
//   io_limit     inclusive upper bound of the counting range
//   io_load      synchronous load strobe; overrides io_en
//   io_load_val  value loaded on io_load
//   io_clr_ovf   clears io_ovf; a same-edge boundary event wins
//   io_out       current count (registered)
//   io_tc        terminal-count pulse (registered)
//   io_ovf       sticky boundary-event flag (registered)
module mod_counter #(
  parameter int unsigned            WIDTH     = 8,
  parameter logic [WIDTH-1:0]       RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             io_en,
  input  logic             io_up,
  input  logic             io_sat,
  input  logic [WIDTH-1:0] io_limit,
  input  logic             io_load,
  input  logic [WIDTH-1:0] io_load_val,
  input  logic             io_clr_ovf,
  output logic [WIDTH-1:0] io_out,
  output logic             io_tc,
  output logic             io_ovf
);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             tc_q, ovf_q;
  logic             bnd;  // boundary event on this edge

  // Next count and boundary detection. The compare cnt_q < io_limit
  // covers both "in range, step up" and excludes the out-of-range case,
  // so the +1 can never carry out of WIDTH bits.
  always_comb begin
    cnt_d = cnt_q;
    bnd   = 1'b0;
    if (io_load) begin
      // Loaded verbatim, even above io_limit; never a boundary event.
      cnt_d = io_load_val;
    end else if (io_en) begin
      if (io_up) begin
        if (cnt_q < io_limit) begin
          cnt_d = cnt_q + 1'b1;
        end else begin
          // At or above the limit: both are boundary events.
          bnd   = 1'b1;
          cnt_d = io_sat ? io_limit : '0;
        end
      end else begin
        if (cnt_q > io_limit) begin
          // Out of range from above: snap to the limit, no event.
          cnt_d = io_limit;
        end else if (cnt_q == '0) begin
          bnd   = 1'b1;
          cnt_d = io_sat ? '0 : io_limit;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= RESET_VAL;
      tc_q  <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tc_q  <= bnd;
      // Set has priority over clear.
      if (bnd)             ovf_q <= 1'b1;
      else if (io_clr_ovf) ovf_q <= 1'b0;
    end
  end

  assign io_out = cnt_q;
  assign io_tc  = tc_q;
  assign io_ovf = ovf_q;

endmodule
